// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- constants shared by the block-read arbiter.
//   state_e        : arbiter FSM encodings (IDLE, READ, RESP)
//   *_DEF          : default width parameters for mem_arbiter
package mem_arbiter_pkg;

  localparam int WORD_SIZE_DEF  = 32;  // bits per word
  localparam int BLOCK_SIZE_DEF = 8;   // words per block
  localparam int MEM_SIZE_DEF   = 32;  // memory depth in blocks

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick -- combinational grant decision for the two refill requesters.
//   req0, req1 : level requests from requester 0 / requester 1
//   rr_last    : index of the requester granted most recently
//   winner     : index of the requester to grant (0 when neither requests)
// A tie goes to the requester that was not granted last; holding rr_last at
// 1 therefore gives requester 0 fixed priority.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic winner
);

  // Tie break on rr_last, otherwise grant whichever side is requesting.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~rr_last;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates block reads from an I-cache (requester 0) and a
// D-cache (requester 1) onto one shared block memory.
//   clock, reset        : sole clock, synchronous active-high reset
//   req0/req1, addr0/1  : level block-read requests and block addresses
//   ack0/ack1           : one-cycle completion pulse to the owning requester
//   rdata               : captured block, non-zero only in the ack cycle
//   mem_ren             : read enable to the memory (high only in READ)
//   mem_block_address   : block address latched at grant time
//   mem_ready, mem_dout : memory data-valid and block data
//   busy                : high whenever the FSM is not IDLE
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise requester 0 always wins a tie.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int MEM_SIZE   = MEM_SIZE_DEF,
  localparam int LINE_W    = WORD_SIZE * BLOCK_SIZE,
  localparam int ADDR_W    = $clog2(MEM_SIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [LINE_W-1:0] rdata,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_block_address,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_dout,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mem_ren_q, mem_ren_d;
  logic [1:0]          ack_q, ack_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                winner_s;
  logic                rr_last_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                rr_last_q, rr_last_d;
  assign rr_last_s = rr_last_q;
`else
  // Fixed priority: pretending requester 1 was granted last makes 0 win ties.
  assign rr_last_s = 1'b1;
`endif

  arb_pick u_arb_pick (
    .req0    (req0),
    .req1    (req1),
    .rr_last (rr_last_s),
    .winner  (winner_s)
  );

  // Next-state and registered-output computation for the IDLE/READ/RESP FSM.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    mem_ren_d = mem_ren_q;
    busy_d    = busy_q;
    ack_d     = 2'b00;
    rdata_d   = {LINE_W{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d   = READ;
          owner_d   = winner_s;
          // The address is frozen here; later addrN changes are ignored.
          addr_d    = winner_s ? addr1 : addr0;
          mem_ren_d = 1'b1;
          busy_d    = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_last_d = winner_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Completion does not depend on reqN still being high.
        if (mem_ready) begin
          state_d   = RESP;
          mem_ren_d = 1'b0;
          ack_d     = owner_q ? 2'b10 : 2'b01;
          rdata_d   = mem_dout;
        end else begin
          state_d = READ;
        end
      end
      RESP: begin
        // Always pass through IDLE so mem_ren drops before the next access.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_ren_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      mem_ren_q <= 1'b0;
      ack_q     <= 2'b00;
      rdata_q   <= {LINE_W{1'b0}};
      busy_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      mem_ren_q <= mem_ren_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign ack0              = ack_q[0];
  assign ack1              = ack_q[1];
  assign rdata             = rdata_q;
  assign mem_ren           = mem_ren_q;
  assign mem_block_address = addr_q;
  assign busy              = busy_q;

endmodule
